iob_axis_upsizer: RTL
=====================

Name: iob_axis_upsizer

Overview:
- Downstream stage for the AXI-Stream output peripheral: consumes its narrow TDATA_W stream (tdata/tvalid/tready/tlast) and packs consecutive beats into DATA_W-wide words for a wide consumer (system-bus DMA, wide FIFO or memory writer).
- Packing is little-endian (first beat in lowest lane). A frame boundary (tlast) flushes a partial word, with a lane-count qualifier.
- Sustains one input beat per cycle when the output sink is always ready.

Parameters:
- TDATA_W, 8: input stream data width in bits.
- DATA_W, 32: output word width; must be an integer multiple of TDATA_W, so R = DATA_W/TDATA_W >= 1.
- CNT_W, 16: width of the frame and word status counters.

Ports:
- clk_i  input  1  clock.
- rst_n_i  input  1  synchronous active-low reset.
- cke_i  input  1  clock enable; when low, all state holds.
- enable_i  input  1  when low, input acceptance stops; the output register still drains.
- s_tdata_i  input  TDATA_W  input beat data.
- s_tvalid_i  input  1  input beat valid.
- s_tready_o  output  1  input beat accepted when s_tvalid_i & s_tready_o & cke_i.
- s_tlast_i  input  1  last beat of frame.
- m_tdata_o  output  DATA_W  packed word; unused upper lanes are 0.
- m_tvalid_o  output  1  output word valid.
- m_tready_i  input  1  sink ready.
- m_tlast_o  output  1  word closes a frame.
- m_nlanes_o  output  $clog2(R)+1  number of valid lanes in m_tdata_o, range 1..R.
- frame_count_o  output  CNT_W  number of m_tlast_o transfers, wraps modulo 2^CNT_W.
- word_count_o  output  CNT_W  number of output word transfers, wraps.

Behaviour:
- Reset (rst_n_i low at a rising edge with cke_i high):
  - Outputs: m_tvalid_o=0, m_tdata_o=0, m_tlast_o=0, m_nlanes_o=0, frame_count_o=0, word_count_o=0.
  - Internal: accumulator cleared, lane index=0, pending=0.
  - Reset has priority over all events. A partial word or undelivered output word is discarded.
- State:
  - Accumulator acc[DATA_W-1:0] and lane index lane[$clog2(R)-1:0].
  - pending flag: acc holds a completed word that has not yet been moved to the output.
  - Output register: m_tdata, m_tvalid, m_tlast, m_nlanes.
- out_free = ~m_tvalid_o | m_tready_i.
- s_tready_o = enable_i & ~pending. This path is combinational from registered state and enable_i only, with no dependence on s_tvalid_i.
- Accepted beat, non-completing (lane < R-1 and s_tlast_i=0):
  - acc lane[lane] <= s_tdata_i; lane <= lane+1.
- Accepted beat, completing (lane == R-1 or s_tlast_i=1):
  - Word W = acc with the current lane replaced by s_tdata_i; lanes above the current lane are forced to 0. nl = lane+1.
  - If out_free: output register <= {W, tlast=s_tlast_i, nlanes=nl}; m_tvalid <= 1. acc <= 0, lane <= 0.
  - Else: acc <= W; pending <= 1; the stored last flag and stored nl are saved.
- pending=1 and out_free: output register <= stored word/last/nl; pending <= 0; acc <= 0; lane <= 0.
- Output transfer (m_tvalid_o & m_tready_i) with no new load: m_tvalid <= 0.
- Latency: 1 cycle from the completing input beat to m_tvalid_o=1 when the output is free. Otherwise the word waits in pending and input stalls, with s_tready_o low for at least 1 cycle.
- Throughput: R beats per word with no bubbles while m_tready_i=1.
- Counters: word_count_o increments on every output transfer; frame_count_o increments on transfers with m_tlast_o=1. Both wrap at 2^CNT_W-1 -> 0.
- enable_i low mid-word: the partial word is retained and resumes when enable_i returns high. This does not create a flush.
- R=1: every beat is a complete word and m_nlanes_o is always 1. The block degenerates to a registered pipeline stage.
- m_tdata_o, m_tlast_o and m_nlanes_o remain stable while m_tvalid_o=1 and m_tready_i=0.

Test Plan:
- R=4, m_tready_i=1. Beats 0x11,0x22,0x33,0x44, with tlast on 0x44 -> one word 0x44332211, m_nlanes_o=4, m_tlast_o=1, 1 cycle after the last beat. frame_count_o=1, word_count_o=1.
- R=4. Six beats 0x01..0x06, tlast on 0x06 -> words 0x04030201 (nlanes 4, last 0) then 0x00000605 (nlanes 2, last 1). s_tready_o is never deasserted.
- m_tready_i=0 with a word held; complete a second word -> s_tready_o drops the cycle after completion. Raise m_tready_i -> first word out, then second word, with no data loss. Output stays stable while stalled.
- Single-beat frame 0xAB with tlast at lane 0 -> 0x000000AB, nlanes=1, last=1.
- Two beats accepted, then rst_n_i low for 1 cycle, then 4 beats 0xA0..0xA3 -> only 0xA3A2A1A0 is output. Counters read 0 after reset, then 1.
- Run 2^CNT_W+3 single-beat frames (use CNT_W=4) -> frame_count_o wraps to 3. enable_i low mid-word holds the state with s_tready_o=0.

Source files
------------

// File: rtl/iob_axis_upsizer.sv
// iob_axis_upsizer
// Packs a narrow AXI-Stream (TDATA_W) into DATA_W-wide words, little-endian
// (first beat in lane 0). A tlast beat flushes a partial word; m_nlanes_o tells
// how many lanes of m_tdata_o are valid, and unused upper lanes read as zero.
//
// Ports:
//   clk_i, rst_n_i    clock, synchronous active-low reset (honoured only with cke_i high)
//   cke_i             clock enable, all state holds while low
//   enable_i          gates input acceptance; the output register still drains
//   s_tdata_i/s_tvalid_i/s_tready_o/s_tlast_i   narrow input stream
//   m_tdata_o/m_tvalid_o/m_tready_i/m_tlast_o   wide output stream
//   m_nlanes_o        valid lane count of the current output word (1..R)
//   frame_count_o     output transfers carrying m_tlast_o, wrapping
//   word_count_o      output word transfers, wrapping
module iob_axis_upsizer #(
  parameter int unsigned TDATA_W = 8,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned CNT_W   = 16
) (
  input  logic                            clk_i,
  input  logic                            rst_n_i,
  input  logic                            cke_i,
  input  logic                            enable_i,
  input  logic [TDATA_W-1:0]              s_tdata_i,
  input  logic                            s_tvalid_i,
  output logic                            s_tready_o,
  input  logic                            s_tlast_i,
  output logic [DATA_W-1:0]               m_tdata_o,
  output logic                            m_tvalid_o,
  input  logic                            m_tready_i,
  output logic                            m_tlast_o,
  output logic [$clog2(DATA_W/TDATA_W):0] m_nlanes_o,
  output logic [CNT_W-1:0]                frame_count_o,
  output logic [CNT_W-1:0]                word_count_o
);

  localparam int unsigned R      = DATA_W / TDATA_W;
  // Keep the lane index at least one bit wide so R=1 still elaborates.
  localparam int unsigned LANE_W = (R > 1) ? $clog2(R) : 1;
  localparam int unsigned NL_W   = $clog2(R) + 1;

  logic [DATA_W-1:0] acc_q, acc_d;
  logic [LANE_W-1:0] lane_q, lane_d;
  logic              pending_q, pending_d;
  logic              pend_last_q, pend_last_d;
  logic [NL_W-1:0]   pend_nl_q, pend_nl_d;

  logic [DATA_W-1:0] tdata_q, tdata_d;
  logic              tvalid_q, tvalid_d;
  logic              tlast_q, tlast_d;
  logic [NL_W-1:0]   nlanes_q, nlanes_d;
  logic [CNT_W-1:0]  frame_cnt_q, frame_cnt_d;
  logic [CNT_W-1:0]  word_cnt_q, word_cnt_d;

  logic              out_free;
  logic              accept;
  logic              complete;
  logic              xfer;
  logic [DATA_W-1:0] word;
  logic [NL_W-1:0]   nl;

  assign out_free   = ~tvalid_q | m_tready_i;
  // Depends only on registered state and enable_i, never on s_tvalid_i.
  assign s_tready_o = enable_i & ~pending_q;
  assign accept     = s_tvalid_i & s_tready_o;
  assign complete   = accept & ((lane_q == LANE_W'(R - 1)) | s_tlast_i);
  assign xfer       = tvalid_q & m_tready_i;
  assign nl         = NL_W'(lane_q) + NL_W'(1);

  // Accumulator with the incoming beat dropped into the current lane; lanes above
  // it are forced to zero so a flushed partial word carries no stale data.
  always_comb begin
    word = '0;
    for (int unsigned i = 0; i < R; i++) begin
      if (i < 32'(lane_q)) begin
        word[i*TDATA_W +: TDATA_W] = acc_q[i*TDATA_W +: TDATA_W];
      end else if (i == 32'(lane_q)) begin
        word[i*TDATA_W +: TDATA_W] = s_tdata_i;
      end
    end
  end

  always_comb begin
    acc_d       = acc_q;
    lane_d      = lane_q;
    pending_d   = pending_q;
    pend_last_d = pend_last_q;
    pend_nl_d   = pend_nl_q;
    tdata_d     = tdata_q;
    tvalid_d    = tvalid_q & ~xfer;
    tlast_d     = tlast_q;
    nlanes_d    = nlanes_q;
    frame_cnt_d = frame_cnt_q;
    word_cnt_d  = word_cnt_q;

    if (xfer) begin
      word_cnt_d = word_cnt_q + CNT_W'(1);
      if (tlast_q) begin
        frame_cnt_d = frame_cnt_q + CNT_W'(1);
      end
    end

    if (pending_q) begin
      // Input is stalled while pending, so only the stored word can move.
      if (out_free) begin
        tdata_d   = acc_q;
        tlast_d   = pend_last_q;
        nlanes_d  = pend_nl_q;
        tvalid_d  = 1'b1;
        pending_d = 1'b0;
        acc_d     = '0;
        lane_d    = '0;
      end
    end else if (accept) begin
      if (complete) begin
        if (out_free) begin
          tdata_d  = word;
          tlast_d  = s_tlast_i;
          nlanes_d = nl;
          tvalid_d = 1'b1;
          acc_d    = '0;
          lane_d   = '0;
        end else begin
          acc_d       = word;
          pending_d   = 1'b1;
          pend_last_d = s_tlast_i;
          pend_nl_d   = nl;
        end
      end else begin
        acc_d  = word;
        lane_d = lane_q + LANE_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (cke_i) begin
      if (!rst_n_i) begin
        acc_q       <= '0;
        lane_q      <= '0;
        pending_q   <= 1'b0;
        pend_last_q <= 1'b0;
        pend_nl_q   <= '0;
        tdata_q     <= '0;
        tvalid_q    <= 1'b0;
        tlast_q     <= 1'b0;
        nlanes_q    <= '0;
        frame_cnt_q <= '0;
        word_cnt_q  <= '0;
      end else begin
        acc_q       <= acc_d;
        lane_q      <= lane_d;
        pending_q   <= pending_d;
        pend_last_q <= pend_last_d;
        pend_nl_q   <= pend_nl_d;
        tdata_q     <= tdata_d;
        tvalid_q    <= tvalid_d;
        tlast_q     <= tlast_d;
        nlanes_q    <= nlanes_d;
        frame_cnt_q <= frame_cnt_d;
        word_cnt_q  <= word_cnt_d;
      end
    end
  end

  assign m_tdata_o     = tdata_q;
  assign m_tvalid_o    = tvalid_q;
  assign m_tlast_o     = tlast_q;
  assign m_nlanes_o    = nlanes_q;
  assign frame_count_o = frame_cnt_q;
  assign word_count_o  = word_cnt_q;

endmodule
